vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator and successor to the fixed 640x480 generator. Runs on the 50 MHz system clock and derives a pixel strobe through a programmable divider. Produces HS/VS/blank, visible-pixel row/col, and line/frame pulses that the framebuffer and pixel pipelines consume. Every timing figure (porches, sync widths, visible extent, divider, sync polarity) is a parameter; the defaults reproduce 640x480 at 60 Hz with a 521-line frame.

Parameters:
CLK_DIV, 2, CLOCK_50 cycles per pixel; legal range is 1 and up.
H_SYNC, 96, horizontal sync width in pixels.
H_BP, 48, horizontal back porch in pixels.
H_VIS, 640, visible pixels per line.
H_FP, 16, horizontal front porch in pixels.
V_SYNC, 2, vertical sync width in lines.
V_BP, 29, vertical back porch in lines.
V_VIS, 480, visible lines.
V_FP, 10, vertical front porch in lines.
SYNC_ACT_LOW, 1, 1 means HS/VS are low while in the sync pulse; 0 means high.
COL_W, 10, col width; must satisfy 2^COL_W >= H_VIS.
ROW_W, 9, row width; must satisfy 2^ROW_W >= V_VIS.

Ports:
CLOCK_50  in  1  system clock.
reset  in  1  synchronous, active-high reset.
en  in  1  run enable; when low, all counters freeze.
pix_en  out  1  one-cycle pixel strobe.
HS  out  1  horizontal sync.
VS  out  1  vertical sync.
blank  out  1  high outside the visible region.
row  out  ROW_W  visible line index.
col  out  COL_W  visible pixel index.
line_start  out  1  one-cycle pulse at the start of each line.
frame_start  out  1  one-cycle pulse at the start of each frame.

Behaviour:
- Axis ordering is sync, then back porch, then visible, then front porch. Counter value 0 is the first cycle of the sync pulse.
- Derived totals: H_TOT = H_SYNC+H_BP+H_VIS+H_FP (default 800); V_TOT = V_SYNC+V_BP+V_VIS+V_FP (default 521).
- Prescaler pcnt runs 0..CLK_DIV-1 while en is high and wraps to 0.
- pix_en = en & (pcnt == CLK_DIV-1). When CLK_DIV=1, pix_en = en.
- hcnt advances on pix_en and wraps H_TOT-1 -> 0.
- vcnt advances on the pix_en cycle where hcnt == H_TOT-1, and wraps V_TOT-1 -> 0.
- Outputs are combinational decodes of the registered counters (zero latency relative to the counter state):
  - HS sync-active when hcnt < H_SYNC.
  - VS sync-active when vcnt < V_SYNC.
  - The active level of both follows SYNC_ACT_LOW.
  - blank = ~(hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_VIS-1] and vcnt in the matching vertical range).
  - col = hcnt - (H_SYNC+H_BP) and row = vcnt - (V_SYNC+V_BP) while not blanked. Both are forced to 0 while blank.
  - line_start = (hcnt==0) & (pcnt==0) & en.
  - frame_start = line_start & (vcnt==0).
- Reset state (including reset asserted mid-frame, which takes effect on the next edge): pcnt=hcnt=vcnt=0.
  - Resulting outputs: HS and VS sync-active, blank=1, row=0, col=0, pix_en=0.
  - line_start and frame_start assert on the first en-high cycle after reset.
- en low: counters hold, sync and blank outputs hold their decoded values, and all pulses are 0.
- Simultaneous reset and en: reset wins.
- No arithmetic overflow: counter widths are $clog2 of the totals; subtraction is performed only inside the visible range.

Optional Feature:
Macro: VGA_FRAME_CNT_EN.
- Defined: adds output frame_cnt [15:0]. It resets to 0, increments on each frame_start after the first one following reset, and wraps 65535 -> 0.
- Undefined: no port and no counter logic.

Decomposition:
- Package vga_pkg holds:
  - default 640x480 timing localparams;
  - a typedef struct vga_axis_t {sync, bp, vis, fp};
  - function axis_total().
- Sub-module vga_axis_timer, instantiated twice (horizontal and vertical):
  - inputs: step, clear;
  - outputs: count, wrap, in_sync, in_vis, and the visible index.

Test Plan:
- Default parameters, reset released, en=1 -> first blank=0 at clock 49888 (31 lines x 1600 + 144 x 2), with row=0 and col=0.
- Default parameters -> frame_start period is 833600 clocks; VS sync-active for exactly 3200 clocks; HS sync-active for 192 clocks every 1600.
- Default parameters, last visible pixel -> row=479 and col=639 held for 2 clocks, then blank=1 and col=0.
- CLK_DIV=1 with H 2/1/4/1 and V 1/1/3/1 -> pix_en is constant 1 and the frame is 48 clocks; check the full blank/row/col trace.
- Reset pulsed mid-line (hcnt≈400) and en toggled low for 10 clocks -> counters return to 0 and pulses restart; while en is low, outputs freeze and pulses stay 0.
- SYNC_ACT_LOW=0 -> HS and VS polarity inverted, with all other timing identical.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA axis timing type, 640x480@60 defaults, and axis size helpers
package vga_pkg;
  typedef struct packed {
    int sync;
    int bp;
    int vis;
    int fp;
  } vga_axis_t;
  localparam vga_axis_t VGA_H_640 = '{sync: 96, bp: 48, vis: 640, fp: 16};
  localparam vga_axis_t VGA_V_480 = '{sync: 2, bp: 29, vis: 480, fp: 10};
  localparam int VGA_CLK_DIV = 2;
  function automatic int axis_total(vga_axis_t a);
    return a.sync + a.bp + a.vis + a.fp;
  endfunction
  function automatic int axis_width(vga_axis_t a);
    return axis_total(a) > 1 ? $clog2(axis_total(a)) : 1;
  endfunction
endpackage

// File: rtl/vga_axis_timer.sv
// vga_axis_timer: one raster axis counter (sync,bp,vis,fp); ports clk, clear, step -> count, wrap, in_sync, in_vis, idx
module vga_axis_timer import vga_pkg::*; #(
  parameter vga_axis_t AX = VGA_H_640,
  parameter int IW = 10,
  localparam int CW = axis_width(AX)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          step,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          in_sync,
  output logic          in_vis,
  output logic [IW-1:0] idx
);
  localparam int TOT = axis_total(AX);
  localparam int VIS0 = AX.sync + AX.bp;
  always_ff @(posedge clk)
    count <= clear ? '0 : step ? (wrap ? '0 : count + CW'(1)) : count;
  always_comb begin
    wrap = count == CW'(TOT - 1);
    in_sync = count < CW'(AX.sync);
    in_vis = count >= CW'(VIS0) && count <= CW'(VIS0 + AX.vis - 1);
    idx = in_vis ? IW'(count - CW'(VIS0)) : '0;
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing; CLOCK_50, reset, en -> pix_en, HS, VS, blank, row, col, line_start, frame_start (+frame_cnt when VGA_FRAME_CNT_EN)
module vga_timing_gen import vga_pkg::*; #(
  parameter int CLK_DIV = VGA_CLK_DIV,
  parameter int H_SYNC = VGA_H_640.sync,
  parameter int H_BP = VGA_H_640.bp,
  parameter int H_VIS = VGA_H_640.vis,
  parameter int H_FP = VGA_H_640.fp,
  parameter int V_SYNC = VGA_V_480.sync,
  parameter int V_BP = VGA_V_480.bp,
  parameter int V_VIS = VGA_V_480.vis,
  parameter int V_FP = VGA_V_480.fp,
  parameter int SYNC_ACT_LOW = 1,
  parameter int COL_W = 10,
  parameter int ROW_W = 9
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             en,
  output logic             pix_en,
  output logic             HS,
  output logic             VS,
  output logic             blank,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);
  localparam vga_axis_t H_AX = '{sync: H_SYNC, bp: H_BP, vis: H_VIS, fp: H_FP};
  localparam vga_axis_t V_AX = '{sync: V_SYNC, bp: V_BP, vis: V_VIS, fp: V_FP};
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int HW = axis_width(H_AX);
  localparam int VW = axis_width(V_AX);
  localparam logic POL = SYNC_ACT_LOW != 0;
  logic [PW-1:0] pcnt;
  logic pdone;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic h_wrap, h_sync, h_vis, v_sync, v_vis, v_wrap_unused;
  logic [COL_W-1:0] h_idx;
  logic [ROW_W-1:0] v_idx;
  always_ff @(posedge CLOCK_50)
    pcnt <= reset ? '0 : en ? (pdone ? '0 : pcnt + PW'(1)) : pcnt;
  vga_axis_timer #(.AX(H_AX), .IW(COL_W)) u_h (
    .clk(CLOCK_50), .clear(reset), .step(pix_en),
    .count(hcnt), .wrap(h_wrap), .in_sync(h_sync), .in_vis(h_vis), .idx(h_idx)
  );
  vga_axis_timer #(.AX(V_AX), .IW(ROW_W)) u_v (
    .clk(CLOCK_50), .clear(reset), .step(pix_en & h_wrap),
    .count(vcnt), .wrap(v_wrap_unused), .in_sync(v_sync), .in_vis(v_vis), .idx(v_idx)
  );
  always_comb begin
    pdone = pcnt == PW'(CLK_DIV - 1);
    pix_en = en & pdone;
    HS = h_sync ^ POL;
    VS = v_sync ^ POL;
    blank = ~(h_vis & v_vis);
    col = blank ? '0 : h_idx;
    row = blank ? '0 : v_idx;
    line_start = en & (hcnt == '0) & (pcnt == '0);
    frame_start = line_start & (vcnt == '0);
  end
`ifdef VGA_FRAME_CNT_EN
  logic seen;
  always_ff @(posedge CLOCK_50)
    if (reset) begin
      seen <= 1'b0;
      frame_cnt <= '0;
    end else if (frame_start) begin
      seen <= 1'b1;
      frame_cnt <= frame_cnt + {15'd0, seen};
    end
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for a default 640x480 instance and a tiny CLK_DIV=1 active-high-sync instance
module tb_vga_timing_gen;
  typedef struct packed {
    logic hs, vs, blank;
    logic [9:0] row, col;
    logic pix_en, ls, fs;
  } out_t;
  typedef struct {
    int kind;
    bit dut;
    out_t exp;
    int got;
    int want;
    string name;
    int k;
  } sb_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rd = 1'b1, ed = 1'b0, rs = 1'b1, es = 1'b0;
  logic d_pix, d_hs, d_vs, d_blank, d_ls, d_fs;
  logic [8:0] d_row;
  logic [9:0] d_col;
  logic s_pix, s_hs, s_vs, s_blank, s_ls, s_fs;
  logic [8:0] s_row;
  logic [9:0] s_col;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] d_fc, s_fc;
`endif
  vga_timing_gen dut_d (
    .CLOCK_50(clk), .reset(rd), .en(ed), .pix_en(d_pix), .HS(d_hs), .VS(d_vs),
    .blank(d_blank), .row(d_row), .col(d_col), .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(d_fc)
`endif
  );
  vga_timing_gen #(
    .CLK_DIV(1), .H_SYNC(2), .H_BP(1), .H_VIS(4), .H_FP(1),
    .V_SYNC(1), .V_BP(1), .V_VIS(3), .V_FP(1), .SYNC_ACT_LOW(0)
  ) dut_s (
    .CLOCK_50(clk), .reset(rs), .en(es), .pix_en(s_pix), .HS(s_hs), .VS(s_vs),
    .blank(s_blank), .row(s_row), .col(s_col), .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(s_fc)
`endif
  );
  out_t d_out, s_out;
  assign d_out = {d_hs, d_vs, d_blank, {1'b0, d_row}, d_col, d_pix, d_ls, d_fs};
  assign s_out = {s_hs, s_vs, s_blank, {1'b0, s_row}, s_col, s_pix, s_ls, s_fs};
  sb_t q[$];
  int errors = 0, checks = 0;
  int kd = 0, ks = 0, phase = 0;
  int hs_cnt = 0, vs_cnt = 0, fv = -1, last_fs = -1, fs_chk = 0, pz = 0, pl = 0;
  function automatic out_t model(int k, logic en, int div, int hs_, int hb, int hv, int hf,
                                 int vs_, int vb, int vv, int vf, logic act_low);
    out_t o;
    int pc, h, v;
    logic vis;
    pc = k % div;
    h = (k / div) % (hs_ + hb + hv + hf);
    v = (k / div / (hs_ + hb + hv + hf)) % (vs_ + vb + vv + vf);
    vis = h >= hs_ + hb && h < hs_ + hb + hv && v >= vs_ + vb && v < vs_ + vb + vv;
    o.hs = (h < hs_) ? !act_low : act_low;
    o.vs = (v < vs_) ? !act_low : act_low;
    o.blank = !vis;
    o.col = vis ? 10'(h - hs_ - hb) : 10'd0;
    o.row = vis ? 10'(v - vs_ - vb) : 10'd0;
    o.pix_en = en && pc == div - 1;
    o.ls = en && h == 0 && pc == 0;
    o.fs = o.ls && v == 0;
    return o;
  endfunction
  task automatic push_t(bit dut, int k, logic en);
    sb_t e;
    e.kind = 0;
    e.dut = dut;
    e.k = k;
    e.got = 0;
    e.want = 0;
    e.name = dut ? "trace_s" : "trace_d";
    e.exp = dut ? model(k, en, 1, 2, 1, 4, 1, 1, 1, 3, 1, 1'b0)
                : model(k, en, 2, 96, 48, 640, 16, 2, 29, 480, 10, 1'b1);
    q.push_back(e);
  endtask
  task automatic push_m(string n, int got, int want);
    sb_t e;
    e.kind = 1;
    e.dut = 1'b0;
    e.exp = '0;
    e.k = 0;
    e.name = n;
    e.got = got;
    e.want = want;
    q.push_back(e);
  endtask
  task automatic cyc(logic rd_n, logic ed_n, logic rs_n, logic es_n);
    @(posedge clk);
    kd = rd ? 0 : ed ? kd + 1 : kd;
    ks = rs ? 0 : es ? ks + 1 : ks;
    #1;
    rd = rd_n;
    ed = ed_n;
    rs = rs_n;
    es = es_n;
    push_t(1'b0, kd, ed_n);
    push_t(1'b1, ks, es_n);
    #1;
    if (phase == 0) begin
      if (ed) begin
        if (kd >= 1600 && kd < 3200 && !d_hs) hs_cnt++;
        if (!d_vs) vs_cnt++;
        if (!d_blank && fv < 0) fv = kd;
      end
      if (es) begin
        if (!s_pix) pz++;
        if (s_fs) begin
          if (last_fs >= 0 && fs_chk < 3) begin
            push_m("s_frame_period", ks - last_fs, 48);
            fs_chk++;
          end
          last_fs = ks;
        end
      end
    end
    if (phase == 2 && (d_pix || d_ls || d_fs || s_pix || s_ls || s_fs)) pl++;
  endtask
  sb_t me;
  out_t ma;
  always @(negedge clk)
    while (q.size() > 0) begin
      me = q.pop_front();
      checks++;
      if (me.kind == 0) begin
        ma = me.dut ? s_out : d_out;
        if (ma !== me.exp) begin
          errors++;
          if (errors <= 20)
            $display("FAIL %s k=%0d got=%h want=%h (hs,vs,blank,row,col,pix,ls,fs)", me.name, me.k, ma, me.exp);
        end
      end else if (me.got != me.want) begin
        errors++;
        $display("FAIL %s got=%0d want=%0d", me.name, me.got, me.want);
      end
    end
  initial begin
    repeat (2) cyc(1, 0, 1, 0);
    for (int i = 0; i < 49900; i++) cyc(0, 1, 0, 1);
    push_m("d_first_vis", fv, 49888);
    push_m("d_hs_line1", hs_cnt, 192);
    push_m("d_vs_frame", vs_cnt, 3200);
    push_m("s_pix_gaps", pz, 0);
    phase = 1;
    while (kd % 1600 != 800) cyc(0, 1, 0, 1);
    cyc(1, 1, 0, 1);
    cyc(0, 1, 1, 1);
    push_m("d_ls_after_rst", int'(d_ls), 1);
    push_m("d_fs_after_rst", int'(d_fs), 1);
    cyc(0, 1, 0, 1);
    push_m("s_fs_after_rst", int'(s_fs), 1);
    for (int i = 0; i < 500; i++) cyc(0, 1, 0, 1);
    phase = 2;
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
    phase = 3;
    push_m("pulses_en_low", pl, 0);
    for (int i = 0; i < 300; i++) cyc(0, 1, 0, 1);
    for (int i = 0; i < 40; i++) cyc(0, logic'(i % 3 != 0), 0, logic'(i % 2));
    for (int i = 0; i < 3400; i++) cyc(0, 1, 0, 1);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
